arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of cycles a granted port holds its slot (legal range 1..255).
REQ-002 Parameter CNT_W, default 3, width of each port's pending-job counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 job_i  input  4  per-port job pulse, one job per cycle high; bit3=port1 .. bit0=port4.
REQ-006 grant_i  input  4  grant vector from arbiter; 4'b1000=port1, 4'b0100=port2, 4'b0010=port3, 4'b0001=port4.
REQ-007 request_o  output  4  requests to arbiter; bit3 drives REQUEST1 .. bit0 drives REQUEST4.
REQ-008 go_o  output  4  per-port access enable, high for the whole HOLD phase.
REQ-009 done_o  output  4  per-port one-cycle pulse at end of HOLD.
REQ-010 pend_full_o  output  4  per-port pending counter at 2^CNT_W-1.
REQ-011 drop_o  output  4  per-port one-cycle pulse when a job is lost to saturation.
REQ-012 err_o  output  1  sticky grant-protocol error flag.

Function
REQ-013 Each port runs an independent FSM: IDLE, REQ, HOLD, RELEASE.
REQ-014 Pending counter: +1 on job_i, -1 on grant acceptance, unchanged when both occur in the same cycle, saturates at 2^CNT_W-1; a job arriving at saturation with no simultaneous acceptance is dropped and drop_o pulses.
REQ-015 IDLE -> REQ when the registered pending count is nonzero; a job sampled at edge k therefore gives request_o high after edge k+1.
REQ-016 request_o[p] is high exactly in REQ and HOLD; it is decoded from registered state only.
REQ-017 REQ -> HOLD at the edge where grant_i[p]=1 (acceptance); the hold counter loads HOLD_CYCLES-1.
REQ-018 go_o[p] is high exactly in HOLD, for HOLD_CYCLES cycles.
REQ-019 HOLD -> RELEASE when the hold counter is 0; done_o[p] is high during the first RELEASE cycle only.
REQ-020 RELEASE lasts exactly 2 cycles with request_o[p] low, so the arbiter always samples a falling edge and can re-enqueue the port; RELEASE -> IDLE after that.
REQ-021 grant_i[p] is ignored in IDLE, HOLD and RELEASE; a stale grant that is still present never causes a second acceptance.
REQ-022 err_o sets at any edge where grant_i has more than one bit set, or where grant_i[p]=1 while port p is in IDLE and its pending count is 0; it clears only on reset.
REQ-023 Back-to-back jobs on one port produce a full REQ/HOLD/RELEASE cycle per job, with no merging.
REQ-024 The four ports never interact except through err_o.

Reset
REQ-025 While rst_n=0: all FSMs are in IDLE, counters are 0, and request_o, go_o, done_o, drop_o, pend_full_o and err_o are all 0, taking effect immediately without a clock edge.
REQ-026 Reset in mid-HOLD discards the pending jobs and does not pulse done_o; operation resumes on the first clk edge after rst_n rises.

Structure
REQ-027 Shared package arb_pkg holds the port FSM state enum, the port-index constants (P1=3..P4=0) and the four one-hot grant encodings.
REQ-028 Sub-module arb_req_port holds one port's FSM, pending counter and hold counter; the top instantiates it 4 times and adds err_o detection.

Verification (HOLD_CYCLES=4, CNT_W=3)
REQ-029 Single job_i=4'b1000 at edge 0; grant_i=4'b1000 at edge 4 -> request_o[3] high edges 1..7 (after edge 1), go_o[3] high 4 cycles after edge 4, done_o[3] pulse after edge 8, request_o[3] low 2 cycles, then IDLE.
REQ-030 8 job pulses on port2 with no grant -> pend_full_o[1]=1 after the 7th, drop_o[1] pulse on the 8th, count stays at 7.
REQ-031 Job and grant acceptance in the same cycle on port3 with count 2 -> count remains 2.
REQ-032 grant_i=4'b1100 for one cycle -> err_o=1 and stays 1 until rst_n=0.
REQ-033 grant_i=4'b0001 held through and after port4's HOLD -> exactly one go_o[0] window of 4 cycles, and err_o stays 0 while pending is nonzero.
REQ-034 rst_n low in the 2nd HOLD cycle -> go_o and request_o drop to 0 asynchronously, no done_o pulse, counters return to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the arbiter requester block:
//   - port_state_t : per-port FSM state encoding
//   - P1..P4       : bit index of each port inside the 4-bit vectors
//   - GNT_P1..P4   : one-hot grant encodings driven by the arbiter
//   - multi_hot()  : true when more than one bit of a 4-bit vector is set
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } port_state_t;

    localparam int NUM_PORTS = 4;

    // Port 1 lives in the MSB, port 4 in the LSB of every vector.
    localparam int P1 = 3;
    localparam int P2 = 2;
    localparam int P3 = 1;
    localparam int P4 = 0;

    localparam logic [3:0] GNT_P1 = 4'b1000;
    localparam logic [3:0] GNT_P2 = 4'b0100;
    localparam logic [3:0] GNT_P3 = 4'b0010;
    localparam logic [3:0] GNT_P4 = 4'b0001;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/arb_if.sv
// ---------------------------------------------------------------------------
// arb_if
// Bundles the job/grant inputs and the request/status outputs of
// arb_requester.
//   job_i       : per-port job pulses            (requester input)
//   grant_i     : one-hot grant from arbiter     (requester input)
//   request_o   : per-port request to arbiter    (requester output)
//   go_o        : per-port access enable         (requester output)
//   done_o      : per-port end-of-hold pulse     (requester output)
//   pend_full_o : per-port pending counter full  (requester output)
//   drop_o      : per-port dropped-job pulse     (requester output)
//   err_o       : sticky grant protocol error    (requester output)
// Modports: master = the requester block, slave = arbiter/job source side.
// ---------------------------------------------------------------------------
interface arb_if;

    logic [3:0] job_i;
    logic [3:0] grant_i;
    logic [3:0] request_o;
    logic [3:0] go_o;
    logic [3:0] done_o;
    logic [3:0] pend_full_o;
    logic [3:0] drop_o;
    logic       err_o;

    modport master (
        input  job_i,
        input  grant_i,
        output request_o,
        output go_o,
        output done_o,
        output pend_full_o,
        output drop_o,
        output err_o
    );

    modport slave (
        output job_i,
        output grant_i,
        input  request_o,
        input  go_o,
        input  done_o,
        input  pend_full_o,
        input  drop_o,
        input  err_o
    );

endinterface

// File: rtl/arb_req_port.sv
// ---------------------------------------------------------------------------
// arb_req_port
// One requester port: pending-job counter, IDLE/REQ/HOLD/RELEASE FSM and
// hold counter. All outputs are registers so they clear immediately on
// asynchronous reset and never glitch.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_job          : job pulse (one job per high cycle)
//   i_grant        : this port's bit of the arbiter grant vector
//   o_request      : request to arbiter, high in REQ and HOLD
//   o_go           : access enable, high in HOLD
//   o_done         : pulse in the first RELEASE cycle
//   o_pend_full    : pending counter saturated
//   o_drop         : pulse when a job is lost to saturation
//   o_idle_empty   : IDLE with nothing pending (used for grant error check)
// ---------------------------------------------------------------------------
module arb_req_port
    import arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_job,
    input  logic i_grant,
    output logic o_request,
    output logic o_go,
    output logic o_done,
    output logic o_pend_full,
    output logic o_drop,
    output logic o_idle_empty
);

    localparam logic [CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    port_state_t      r_state;
    logic [CNT_W-1:0] r_pend;
    logic [7:0]       r_hold;
    logic             r_rel;
    logic             r_request;
    logic             r_go;
    logic             r_done;
    logic             r_pend_full;
    logic             r_drop;

    logic             w_accept;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             w_drop_nxt;

    // Grants only count while requesting; stale grants elsewhere are ignored.
    assign w_accept = (r_state == ST_REQ) && i_grant;

    // A job and an acceptance in the same cycle cancel out.
    always_comb begin
        w_pend_nxt = r_pend;
        w_drop_nxt = 1'b0;
        if (i_job && !w_accept) begin
            if (r_pend == PEND_MAX) begin
                w_drop_nxt = 1'b1;
            end else begin
                w_pend_nxt = r_pend + 1'b1;
            end
        end else if (!i_job && w_accept) begin
            w_pend_nxt = r_pend - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_hold      <= '0;
            r_rel       <= 1'b0;
            r_request   <= 1'b0;
            r_go        <= 1'b0;
            r_done      <= 1'b0;
            r_pend_full <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_pend_full <= (w_pend_nxt == PEND_MAX);
            r_drop      <= w_drop_nxt;
            r_done      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Uses the registered count, so a new job costs one cycle.
                    if (r_pend != '0) begin
                        r_state   <= ST_REQ;
                        r_request <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_grant) begin
                        r_state <= ST_HOLD;
                        r_hold  <= HOLD_LOAD;
                        r_go    <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_hold == '0) begin
                        r_state   <= ST_RELEASE;
                        r_rel     <= 1'b0;
                        r_go      <= 1'b0;
                        r_request <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
                end
                ST_RELEASE: begin
                    // Two low-request cycles guarantee the arbiter sees a falling edge.
                    if (!r_rel) begin
                        r_rel <= 1'b1;
                    end else begin
                        r_rel   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_request <= 1'b0;
                    r_go      <= 1'b0;
                end
            endcase
        end
    end

    assign o_request    = r_request;
    assign o_go         = r_go;
    assign o_done       = r_done;
    assign o_pend_full  = r_pend_full;
    assign o_drop       = r_drop;
    assign o_idle_empty = (r_state == ST_IDLE) && (r_pend == '0);

endmodule

// File: rtl/arb_requester.sv
// ---------------------------------------------------------------------------
// arb_requester
// Four independent requester ports in front of a one-hot grant arbiter,
// plus a sticky grant-protocol error flag.
// Ports:
//   clk   : clock, all state changes on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arb_if.master (job_i, grant_i in; request_o, go_o, done_o,
//           pend_full_o, drop_o, err_o out)
// Parameters:
//   HOLD_CYCLES : cycles a granted port holds its slot (1..255)
//   CNT_W       : width of each port's pending-job counter
// ---------------------------------------------------------------------------
module arb_requester
    import arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    arb_if.master    bus
);

    logic [NUM_PORTS-1:0] w_request;
    logic [NUM_PORTS-1:0] w_go;
    logic [NUM_PORTS-1:0] w_done;
    logic [NUM_PORTS-1:0] w_pend_full;
    logic [NUM_PORTS-1:0] w_drop;
    logic [NUM_PORTS-1:0] w_idle_empty;
    logic                 w_err_set;
    logic                 r_err;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        arb_req_port #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_port (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_job        (bus.job_i[p]),
            .i_grant      (bus.grant_i[p]),
            .o_request    (w_request[p]),
            .o_go         (w_go[p]),
            .o_done       (w_done[p]),
            .o_pend_full  (w_pend_full[p]),
            .o_drop       (w_drop[p]),
            .o_idle_empty (w_idle_empty[p])
        );
    end

    // A grant is illegal if it is not one-hot, or if it targets a port that
    // has nothing to ask for.
    assign w_err_set = multi_hot(bus.grant_i) || ((bus.grant_i & w_idle_empty) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign bus.request_o   = w_request;
    assign bus.go_o        = w_go;
    assign bus.done_o      = w_done;
    assign bus.pend_full_o = w_pend_full;
    assign bus.drop_o      = w_drop;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
    import arb_pkg::*;

    localparam int H    = 4;
    localparam int CW   = 3;
    localparam int PMAX = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    arb_if bus ();

    arb_requester #(
        .HOLD_CYCLES (H),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per port, pending job count, whether it is waiting for
    // a grant, and the number of edges since its grant was accepted (-1 when
    // no slot is in progress).
    int m_pend [4];
    bit m_wait [4];
    int m_age  [4];
    bit m_drop [4];
    bit m_err;

    function automatic bit m_idle(input int p);
        return !m_wait[p] && (m_age[p] < 0);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            m_pend[p] = 0;
            m_wait[p] = 1'b0;
            m_age[p]  = -1;
            m_drop[p] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] j;
        logic [3:0] g;
        bit e;
        bit acc;
        bit was_idle;
        int pb;
        j = bus.job_i;
        g = bus.grant_i;
        e = ($countones(g) > 1);
        for (int p = 0; p < 4; p++)
            if (g[p] && m_idle(p) && m_pend[p] == 0) e = 1'b1;
        for (int p = 0; p < 4; p++) begin
            was_idle  = m_idle(p);
            pb        = m_pend[p];
            acc       = m_wait[p] && g[p];
            m_drop[p] = 1'b0;
            if (j[p] && !acc) begin
                if (pb == PMAX) m_drop[p] = 1'b1;
                else m_pend[p] = pb + 1;
            end else if (!j[p] && acc) begin
                m_pend[p] = pb - 1;
            end
            if (acc) begin
                m_wait[p] = 1'b0;
                m_age[p]  = 0;
            end else if (m_age[p] >= 0) begin
                m_age[p] = m_age[p] + 1;
                if (m_age[p] == H + 2) m_age[p] = -1;
            end else if (was_idle && pb > 0) begin
                m_wait[p] = 1'b1;
            end
        end
        if (e) m_err = 1'b1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e_req, e_go, e_done, e_full, e_drop;
        for (int p = 0; p < 4; p++) begin
            e_go[p]   = (m_age[p] >= 0) && (m_age[p] < H);
            e_req[p]  = m_wait[p] || e_go[p];
            e_done[p] = (m_age[p] == H);
            e_full[p] = (m_pend[p] == PMAX);
            e_drop[p] = m_drop[p];
        end
        chk4({tag, ".request"}, bus.request_o, e_req);
        chk4({tag, ".go"}, bus.go_o, e_go);
        chk4({tag, ".done"}, bus.done_o, e_done);
        chk4({tag, ".pend_full"}, bus.pend_full_o, e_full);
        chk4({tag, ".drop"}, bus.drop_o, e_drop);
        chk4({tag, ".err"}, {3'b000, bus.err_o}, {3'b000, m_err});
    endtask

    // One rising edge; the model steps on the same input values, and all
    // outputs are compared on the following falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    // Called just after a falling edge: reset must act without any clock edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    // Grants the port whenever the model says it is waiting, until the port
    // is idle with nothing pending. Counts go cycles and done pulses seen.
    task automatic drain(input int p, input string tag, output int ngo, output int ndone);
        bit finished;
        logic [3:0] one;
        one      = 4'b0001 << p;
        ngo      = 0;
        ndone    = 0;
        finished = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            bus.grant_i = m_wait[p] ? one : 4'b0000;
            tick(tag);
            if (bus.go_o[p]) ngo++;
            if (bus.done_o[p]) ndone++;
            if (m_idle(p) && m_pend[p] == 0) finished = 1'b1;
        end
        bus.grant_i = 4'b0000;
        chki({tag, ".finished"}, int'(finished), 1);
    endtask

    int ngo, ndone;
    int r;

    initial begin
        model_reset();
        bus.job_i   = 4'b0000;
        bus.grant_i = 4'b0000;

        // Reset state
        #2;
        async_reset("reset");
        tick("reset_hold");
        tick("reset_hold");
        rst_n = 1'b1;
        tick("post_reset");

        // Single job on port 1, grant four cycles later
        bus.job_i = GNT_P1;
        tick("p1_e0");
        chk4("p1_e0_req", bus.request_o, 4'b0000);
        bus.job_i = 4'b0000;
        tick("p1_e1");
        chk4("p1_e1_req", bus.request_o, 4'b1000);
        tick("p1_e2");
        tick("p1_e3");
        bus.grant_i = GNT_P1;
        tick("p1_e4");
        chk4("p1_e4_go", bus.go_o, 4'b1000);
        bus.grant_i = 4'b0000;
        ngo = 1;
        for (int i = 5; i <= 7; i++) begin
            tick("p1_hold");
            if (bus.go_o[P1]) ngo++;
        end
        chki("p1_go_cycles", ngo, 4);
        tick("p1_e8");
        chk4("p1_e8_done", bus.done_o, 4'b1000);
        chk4("p1_e8_req", bus.request_o, 4'b0000);
        tick("p1_e9");
        chk4("p1_e9_done", bus.done_o, 4'b0000);
        chk4("p1_e9_req", bus.request_o, 4'b0000);
        tick("p1_e10");
        tick("p1_e11");
        chk4("p1_e11_req", bus.request_o, 4'b0000);

        // Saturation on port 2
        for (int i = 1; i <= 8; i++) begin
            bus.job_i = GNT_P2;
            tick("p2_fill");
            if (i == 6) chk4("p2_full_after6", bus.pend_full_o, 4'b0000);
            if (i == 7) begin
                chk4("p2_full_after7", bus.pend_full_o, 4'b0100);
                chk4("p2_nodrop_after7", bus.drop_o, 4'b0000);
            end
            if (i == 8) begin
                chk4("p2_drop_after8", bus.drop_o, 4'b0100);
                chk4("p2_full_after8", bus.pend_full_o, 4'b0100);
            end
        end
        bus.job_i = 4'b0000;
        tick("p2_after");
        chk4("p2_drop_cleared", bus.drop_o, 4'b0000);
        drain(P2, "p2_drain", ngo, ndone);
        chki("p2_windows", ndone, 7);
        chki("p2_go_total", ngo, 7 * H);

        // Job and acceptance together on port 3 with two pending
        bus.job_i = GNT_P3;
        tick("p3_job1");
        tick("p3_job2");
        bus.grant_i = GNT_P3;
        tick("p3_job_acc");
        chk4("p3_acc_go", bus.go_o, 4'b0010);
        bus.job_i   = 4'b0000;
        bus.grant_i = 4'b0000;
        drain(P3, "p3_drain", ngo, ndone);
        chki("p3_windows", ndone, 3);

        // Port 4 grant held through and after the hold phase
        bus.job_i = GNT_P4;
        tick("p4_job");
        bus.job_i = 4'b0000;
        ngo   = 0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            bus.grant_i = (m_idle(P4) && m_pend[P4] == 0) ? 4'b0000 : GNT_P4;
            if (bus.grant_i != 4'b0000) begin
                tick("p4_stale");
                if (bus.go_o[P4]) ngo++;
                if (bus.done_o[P4]) ndone++;
            end
        end
        chki("p4_go_cycles", ngo, H);
        chki("p4_done_pulses", ndone, 1);
        chk4("p4_err", {3'b000, bus.err_o}, 4'b0000);

        // Reset during the second hold cycle of port 1
        bus.job_i = GNT_P1;
        tick("p1r_job");
        tick("p1r_job");
        tick("p1r_job");
        bus.job_i   = 4'b0000;
        bus.grant_i = GNT_P1;
        tick("p1r_acc");
        bus.grant_i = 4'b0000;
        tick("p1r_hold2");
        chk4("p1r_go_before", bus.go_o, 4'b1000);
        async_reset("p1r_rst");
        chk4("p1r_go_async", bus.go_o, 4'b0000);
        chk4("p1r_req_async", bus.request_o, 4'b0000);
        tick("p1r_in_rst");
        chk4("p1r_no_done", bus.done_o, 4'b0000);
        tick("p1r_in_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick("p1r_after");
        chk4("p1r_pending_gone", bus.request_o, 4'b0000);

        // Multi-bit grant sets the sticky error
        bus.grant_i = GNT_P1 | GNT_P2;
        tick("err_set");
        chk4("err_set", {3'b000, bus.err_o}, 4'b0001);
        bus.grant_i = 4'b0000;
        for (int i = 0; i < 3; i++) tick("err_sticky");
        chk4("err_sticky", {3'b000, bus.err_o}, 4'b0001);
        async_reset("err_rst");
        chk4("err_cleared", {3'b000, bus.err_o}, 4'b0000);
        tick("err_rst_hold");
        rst_n = 1'b1;
        tick("err_after");

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 4; p++) bus.job_i[p] = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 15);
                if (r < 6) begin
                    bus.grant_i = 4'b0001 << $urandom_range(0, 3);
                end else if (r == 6) begin
                    bus.grant_i = 4'($urandom_range(0, 15));
                end else if (r < 12) begin
                    bus.grant_i = 4'b0000;
                    for (int p = 0; p < 4; p++)
                        if (m_wait[p] && bus.grant_i == 4'b0000) bus.grant_i = 4'b0001 << p;
                end else begin
                    bus.grant_i = 4'b0000;
                end
            end
            if (c % 250 == 249) begin
                async_reset("rnd_rst");
                tick("rnd_rst_hold");
                rst_n = 1'b1;
            end else begin
                tick("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
